// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU types for the OAM scan unit
package ppu_pkg;

  localparam logic [15:0] OAM_BASE_ADDR = 16'hFE00;
  localparam int          OBJ_BYTES     = 4;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] tile;
    logic [7:0] attr;
  } obj_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_Y,
    S_EVAL_Y,
    S_GET_X,
    S_GET_T,
    S_GET_A,
    S_DONE
  } scan_state_e;

  // OAM Y is offset by 16, so compare against ly+16 in 9 bits to avoid wrap.
  function automatic logic obj_on_line(input logic [7:0] ly,
                                       input logic [7:0] y,
                                       input logic       tall);
    logic [8:0] line9;
    logic [8:0] top9;
    logic [8:0] bottom9;
    line9   = {1'b0, ly} + 9'd16;
    top9    = {1'b0, y};
    bottom9 = top9 + (tall ? 9'd16 : 9'd8);
    return (line9 >= top9) && (line9 < bottom9);
  endfunction

endpackage

// File: rtl/oam_obj_buffer.sv
// rtl/oam_obj_buffer.sv - per-line object buffer with clear, commit and indexed read
// OAM_SCAN_XSORT_EN: commit becomes a stable ordered insert by X (leftmost at index 0).
module oam_obj_buffer
  import ppu_pkg::*;
#(
  parameter int MAX_PER_LINE = 10,
  parameter int CW           = $clog2(MAX_PER_LINE + 1),
  parameter int RW           = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          clr_i,
  input  logic          commit_i,
  input  obj_entry_t    entry_i,
  output logic [CW-1:0] count_o,
  input  logic [RW-1:0] rd_idx_i,
  output obj_entry_t    rd_entry_o
);

  obj_entry_t    slot_q [MAX_PER_LINE];
  obj_entry_t    slot_d [MAX_PER_LINE];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          room;

  assign room    = count_q < CW'(MAX_PER_LINE);
  assign count_o = count_q;

`ifdef OAM_SCAN_XSORT_EN
  logic [CW-1:0] ins_pos;

  // Buffer is kept sorted, so counting entries with x <= new x gives the slot
  // just after any equal-X entries, preserving OAM order among ties.
  always_comb begin
    ins_pos = '0;
    for (int k = 0; k < MAX_PER_LINE; k++) begin
      if (CW'(k) < count_q && slot_q[k].x <= entry_i.x) begin
        ins_pos = ins_pos + CW'(1);
      end
    end
  end
`endif

  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (clr_i) begin
      for (int k = 0; k < MAX_PER_LINE; k++) begin
        slot_d[k] = '0;
      end
      count_d = '0;
    end else if (commit_i && room) begin
      count_d = count_q + CW'(1);
`ifdef OAM_SCAN_XSORT_EN
      for (int k = 1; k < MAX_PER_LINE; k++) begin
        if (CW'(k) > ins_pos && CW'(k) <= count_q) begin
          slot_d[k] = slot_q[k-1];
        end
      end
      for (int k = 0; k < MAX_PER_LINE; k++) begin
        if (CW'(k) == ins_pos) begin
          slot_d[k] = entry_i;
        end
      end
`else
      for (int k = 0; k < MAX_PER_LINE; k++) begin
        if (CW'(k) == count_q) begin
          slot_d[k] = entry_i;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < MAX_PER_LINE; k++) begin
        slot_q[k] <= '0;
      end
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    rd_entry_o = '0;
    for (int k = 0; k < MAX_PER_LINE; k++) begin
      if (RW'(k) == rd_idx_i && CW'(k) < count_q) begin
        rd_entry_o = slot_q[k];
      end
    end
  end

endmodule

// File: rtl/oam_scan_unit.sv
// rtl/oam_scan_unit.sv - mode-2 OAM scan: selects objects on scanline ly into a line buffer
// Buffer ordering follows OAM order unless OAM_SCAN_XSORT_EN is defined (sorted by X).
module oam_scan_unit
  import ppu_pkg::*;
#(
  parameter int          NUM_OBJ      = 40,
  parameter int          MAX_PER_LINE = 10,
  parameter logic [15:0] OAM_BASE     = OAM_BASE_ADDR,
  parameter int          CW           = $clog2(MAX_PER_LINE + 1),
  localparam int         RW           = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1,
  localparam int         IW           = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [7:0]    ly_i,
  input  logic          tall_i,
  output logic          mem_rd_o,
  output logic [15:0]   mem_addr_o,
  input  logic [7:0]    mem_data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] count_o,
  input  logic [RW-1:0] rd_idx_i,
  output logic [7:0]    rd_y_o,
  output logic [7:0]    rd_x_o,
  output logic [7:0]    rd_tile_o,
  output logic [7:0]    rd_attr_o
);

  scan_state_e   state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [7:0]    ly_q, ly_d;
  logic          tall_q, tall_d;
  logic [7:0]    y_q, y_d;
  logic [7:0]    x_q, x_d;
  logic [7:0]    tile_q, tile_d;

  logic          buf_clr;
  logic          buf_commit;
  obj_entry_t    commit_entry;
  obj_entry_t    rd_entry;
  logic [CW-1:0] count_w;
  logic [15:0]   obj_addr;
  logic          last_obj;
  logic          room;

  assign obj_addr = OAM_BASE + 16'(i_q) * 16'(OBJ_BYTES);
  assign last_obj = (i_q == IW'(NUM_OBJ - 1));
  assign room     = count_w < CW'(MAX_PER_LINE);
  assign busy_o   = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    ly_d       = ly_q;
    tall_d     = tall_q;
    y_d        = y_q;
    x_d        = x_q;
    tile_d     = tile_q;
    buf_clr    = 1'b0;
    buf_commit = 1'b0;
    mem_rd_o   = 1'b0;
    mem_addr_o = OAM_BASE;
    done_o     = 1'b0;

    unique case (state_q)
      S_IDLE: ;
      S_REQ_Y: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = obj_addr;
        state_d    = S_EVAL_Y;
      end
      S_EVAL_Y: begin
        mem_addr_o = obj_addr;
        // A hit with a full buffer is treated as a miss: same 2-cycle cost.
        if (obj_on_line(ly_q, mem_data_i, tall_q) && room) begin
          y_d        = mem_data_i;
          mem_rd_o   = 1'b1;
          mem_addr_o = obj_addr + 16'd1;
          state_d    = S_GET_X;
        end else begin
          i_d     = i_q + IW'(1);
          state_d = last_obj ? S_DONE : S_REQ_Y;
        end
      end
      S_GET_X: begin
        x_d        = mem_data_i;
        mem_rd_o   = 1'b1;
        mem_addr_o = obj_addr + 16'd2;
        state_d    = S_GET_T;
      end
      S_GET_T: begin
        tile_d     = mem_data_i;
        mem_rd_o   = 1'b1;
        mem_addr_o = obj_addr + 16'd3;
        state_d    = S_GET_A;
      end
      S_GET_A: begin
        mem_addr_o = obj_addr + 16'd3;
        buf_commit = 1'b1;
        i_d        = i_q + IW'(1);
        state_d    = last_obj ? S_DONE : S_REQ_Y;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_i) begin
      ly_d    = ly_i;
      tall_d  = tall_i;
      i_d     = '0;
      buf_clr = 1'b1;
      state_d = S_REQ_Y;
    end

    // Abort wins over start and suppresses any in-flight read or done pulse.
    if (abort_i) begin
      i_d        = '0;
      buf_clr    = 1'b1;
      buf_commit = 1'b0;
      mem_rd_o   = 1'b0;
      done_o     = 1'b0;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      ly_q    <= '0;
      tall_q  <= 1'b0;
      y_q     <= '0;
      x_q     <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      ly_q    <= ly_d;
      tall_q  <= tall_d;
      y_q     <= y_d;
      x_q     <= x_d;
      tile_q  <= tile_d;
    end
  end

  assign commit_entry = '{y: y_q, x: x_q, tile: tile_q, attr: mem_data_i};

  oam_obj_buffer #(
    .MAX_PER_LINE (MAX_PER_LINE),
    .CW           (CW),
    .RW           (RW)
  ) u_obj_buffer (
    .clk        (clk),
    .rstN       (rstN),
    .clr_i      (buf_clr),
    .commit_i   (buf_commit),
    .entry_i    (commit_entry),
    .count_o    (count_w),
    .rd_idx_i   (rd_idx_i),
    .rd_entry_o (rd_entry)
  );

  assign count_o   = count_w;
  assign rd_y_o    = rd_entry.y;
  assign rd_x_o    = rd_entry.x;
  assign rd_tile_o = rd_entry.tile;
  assign rd_attr_o = rd_entry.attr;

endmodule

// File: tb/tb_oam_scan_unit.sv
// tb/tb_oam_scan_unit.sv - randomized bench for oam_scan_unit against a queue-based line model
module tb_oam_scan_unit;

  localparam int NUM_OBJ = 40;
  localparam int MAXN    = 10;
  localparam int CW      = 4;
  localparam int RW      = 4;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    ly = 8'd0;
  logic          tall = 1'b0;
  logic          mem_rd;
  logic [15:0]   mem_addr;
  logic [7:0]    mem_data = 8'd0;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic [RW-1:0] rd_idx = '0;
  logic [7:0]    rd_y, rd_x, rd_tile, rd_attr;

  oam_scan_unit dut (
    .clk        (clk),
    .rstN       (rstN),
    .start_i    (start),
    .abort_i    (abort),
    .ly_i       (ly),
    .tall_i     (tall),
    .mem_rd_o   (mem_rd),
    .mem_addr_o (mem_addr),
    .mem_data_i (mem_data),
    .busy_o     (busy),
    .done_o     (done),
    .count_o    (count),
    .rd_idx_i   (rd_idx),
    .rd_y_o     (rd_y),
    .rd_x_o     (rd_x),
    .rd_tile_o  (rd_tile),
    .rd_attr_o  (rd_attr)
  );

  always #5 clk = ~clk;

  logic [7:0] oam [NUM_OBJ*4];

  always @(posedge clk) begin
    if (mem_rd) mem_data <= oam[(mem_addr - 16'hFE00) % 16'(NUM_OBJ*4)];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    int          x;
  } ref_ent_t;

  ref_ent_t sel[$];
  int       exp_cyc;

  // Reference: walk OAM in order, keep first MAXN objects covering the line.
  task automatic model(input int l, input bit t);
    sel.delete();
    for (int o = 0; o < NUM_OBJ; o++) begin
      int y;
      int h;
      y = int'(oam[4*o]);
      h = t ? 16 : 8;
      if (l + 16 >= y && l + 16 < y + h && sel.size() < MAXN) begin
        ref_ent_t e;
        e.word = {oam[4*o], oam[4*o+1], oam[4*o+2], oam[4*o+3]};
        e.x    = int'(oam[4*o+1]);
`ifdef OAM_SCAN_XSORT_EN
        begin
          int p;
          p = sel.size();
          for (int j = sel.size() - 1; j >= 0; j--) if (sel[j].x > e.x) p = j;
          sel.insert(p, e);
        end
`else
        sel.push_back(e);
`endif
      end
    end
    exp_cyc = 2*NUM_OBJ + 3*sel.size() + 1;
  endtask

  task automatic clear_oam();
    for (int k = 0; k < NUM_OBJ*4; k++) oam[k] = 8'd0;
  endtask

  task automatic set_obj(input int o, input int y, input int x, input int t, input int a);
    oam[4*o]   = 8'(y);
    oam[4*o+1] = 8'(x);
    oam[4*o+2] = 8'(t);
    oam[4*o+3] = 8'(a);
  endtask

  task automatic random_oam(input int l);
    for (int o = 0; o < NUM_OBJ; o++) begin
      int y;
      if ($urandom_range(0, 1) == 1) y = l + $urandom_range(0, 20);
      else y = $urandom_range(0, 255);
      if (y > 255) y = 255;
      set_obj(o, y, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    end
  endtask

  task automatic kick(input int l, input bit t);
    @(negedge clk);
    ly    = 8'(l);
    tall  = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_scan(input string name, input int l, input bit t);
    int cyc;
    model(l, t);
    kick(l, t);
    check({name, ".busy_rise"}, 32'(busy), 32'd1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check({name, ".done_cycles"}, 32'(cyc), 32'(exp_cyc));
    @(negedge clk);
    check({name, ".done_pulse"}, 32'(done), 32'd0);
    check({name, ".busy_end"}, 32'(busy), 32'd0);
    check({name, ".count"}, 32'(count), 32'(sel.size()));
    for (int k = 0; k < 16; k++) begin
      logic [31:0] exp;
      @(negedge clk);
      rd_idx = RW'(k);
      #1;
      exp = (k < sel.size()) ? sel[k].word : 32'd0;
      check($sformatf("%s.entry%0d", name, k), {rd_y, rd_x, rd_tile, rd_attr}, exp);
    end
  endtask

  initial begin
    bit seen_done;
    int pre_count;

    clear_oam();
    #1;
    check("reset.mem_rd", 32'(mem_rd), 32'd0);
    check("reset.mem_addr", 32'(mem_addr), 32'hFE00);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.count", 32'(count), 32'd0);
    check("reset.entry0", {rd_y, rd_x, rd_tile, rd_attr}, 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    run_scan("all_y0", 0, 1'b0);

    clear_oam();
    set_obj(3, 16, 50, 3, 33);
    set_obj(7, 16, 20, 7, 77);
    run_scan("two_hits", 0, 1'b0);
    @(negedge clk);
    rd_idx = '0;
    #1;
`ifdef OAM_SCAN_XSORT_EN
    check("two_hits.idx0_x", 32'(rd_x), 32'd20);
`else
    check("two_hits.idx0_x", 32'(rd_x), 32'd50);
`endif

    clear_oam();
    for (int o = 0; o < 12; o++) set_obj(o, 20, 100 - o, o, o + 1);
    run_scan("overflow", 10, 1'b0);

    clear_oam();
    set_obj(0, 8, 40, 1, 2);
    run_scan("y8_short", 7, 1'b0);
    run_scan("y8_tall", 7, 1'b1);
    clear_oam();
    set_obj(5, 0, 40, 1, 2);
    run_scan("y0_short", 0, 1'b0);
    run_scan("y0_tall", 0, 1'b1);

    clear_oam();
    set_obj(2, 30, 30, 8'h22, 1);
    set_obj(9, 30, 30, 8'h99, 2);
    set_obj(4, 30, 10, 8'h44, 3);
    run_scan("equal_x", 20, 1'b0);
    @(negedge clk);
    rd_idx = '0;
    #1;
`ifdef OAM_SCAN_XSORT_EN
    check("equal_x.idx0_tile", 32'(rd_tile), 32'h44);
`else
    check("equal_x.idx0_tile", 32'(rd_tile), 32'h22);
`endif

    // Abort after three objects have been committed.
    clear_oam();
    for (int o = 0; o < 6; o++) set_obj(o, 20, o, o, o);
    kick(10, 1'b0);
    repeat (19) @(negedge clk);
    pre_count = int'(count);
    check("abort.pre_count", 32'(pre_count), 32'd3);
    abort = 1'b1;
    #1;
    check("abort.mem_rd", 32'(mem_rd), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.count", 32'(count), 32'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("abort.no_done", 32'(seen_done), 32'd0);
    run_scan("after_abort", 5, 1'b0);

    // Asynchronous reset in GET_T of object 0.
    clear_oam();
    set_obj(0, 16, 9, 9, 9);
    kick(0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst.pre_addr", 32'(mem_addr), 32'hFE03);
    rstN = 1'b0;
    #1;
    check("rst.mem_rd", 32'(mem_rd), 32'd0);
    check("rst.mem_addr", 32'(mem_addr), 32'hFE00);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.count", 32'(count), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    run_scan("after_rst", 0, 1'b0);

    // Restart while busy with a different line.
    random_oam(60);
    kick(30, 1'b0);
    repeat (29) @(negedge clk);
    run_scan("restart", 60, 1'b1);

    for (int n = 0; n < 20; n++) begin
      int l;
      bit t;
      l = $urandom_range(0, 159);
      t = 1'($urandom_range(0, 1));
      random_oam(l);
      run_scan($sformatf("rand%0d", n), l, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
